// File: rtl/ghash_sequencer.sv
// GHASH block sequencer: folds each block into the running hash X through an external
// GF(2^128) multiplier (fixed latency) and emits the final hash after the last block.
module ghash_sequencer #(
   parameter int DATA__WIDTH = 128,
   parameter int SPLIT_WIDTH = 32,
   parameter int MUL_LATENCY = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA__WIDTH-1:0] h_i,
   input  logic                   h_load_i,
   input  logic [DATA__WIDTH-1:0] blk_i,
   input  logic                   blk_valid_i,
   input  logic                   blk_last_i,
   output logic                   blk_ready_o,
   output logic [SPLIT_WIDTH-1:0] ha_o,
   output logic [SPLIT_WIDTH-1:0] hb_o,
   output logic [SPLIT_WIDTH-1:0] hc_o,
   output logic [SPLIT_WIDTH-1:0] hd_o,
   output logic [DATA__WIDTH-1:0] a_o,
   input  logic [DATA__WIDTH-1:0] mul_i,
   output logic [DATA__WIDTH-1:0] ghash_o,
   output logic                   ghash_valid_o,
   output logic                   busy_o
);

   localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [DATA__WIDTH-1:0] r_h;
   logic [DATA__WIDTH-1:0] r_z;
   logic [DATA__WIDTH-1:0] r_a;
   logic [DATA__WIDTH-1:0] r_ghash;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_last;
   logic                   w_accept;

   assign w_accept = (r_state == IDLE) && !h_load_i && blk_valid_i;

   // NOTE: state and datapath registers use non-blocking assignments so every flop
   // samples the pre-edge values of its neighbours; blocking here would race.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = ISSUE;
         ISSUE:   w_next = WAIT;
         WAIT:    if (r_cnt == '0) w_next = r_last ? DONE : IDLE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      blk_ready_o   = (r_state == IDLE) && !h_load_i;
      busy_o        = (r_state != IDLE);
      ghash_valid_o = (r_state == DONE);
      a_o           = (r_state == ISSUE) ? r_a : '0;
   end

   // The final hash is latched at capture of the last product, so it is already
   // stable in DONE and then held until the next message completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_h     <= '0;
         r_z     <= '0;
         r_a     <= '0;
         r_ghash <= '0;
         r_cnt   <= '0;
         r_last  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (h_load_i) begin
                  r_h <= h_i;
                  r_z <= '0;
               end else if (blk_valid_i) begin
                  r_a    <= blk_i ^ r_z;
                  r_last <= blk_last_i;
               end
            end
            ISSUE: r_cnt <= CNT_W'(MUL_LATENCY - 1);
            WAIT: begin
               if (r_cnt == '0) begin
                  r_z <= mul_i;
                  if (r_last) r_ghash <= mul_i;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            DONE:    r_z <= '0;
            default: ;
         endcase
      end
   end

   assign ha_o    = r_h[4*SPLIT_WIDTH-1 -: SPLIT_WIDTH];
   assign hb_o    = r_h[3*SPLIT_WIDTH-1 -: SPLIT_WIDTH];
   assign hc_o    = r_h[2*SPLIT_WIDTH-1 -: SPLIT_WIDTH];
   assign hd_o    = r_h[SPLIT_WIDTH-1:0];
   assign ghash_o = r_ghash;

endmodule

// File: tb/tb_ghash_sequencer.sv
// Scoreboard bench for ghash_sequencer: a latency-4 GF(2^128) multiplier stub drives mul_i,
// and a message-level GHASH model predicts each final hash.
module tb_ghash_sequencer;

   localparam logic [127:0] R_POLY = {8'hE1, 120'h0};
   localparam logic [127:0] H_ID   = {1'b1, 127'h0};
   localparam logic [127:0] H_X    = {2'b01, 126'h0};

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] h_i;
   logic         h_load_i;
   logic [127:0] blk_i;
   logic         blk_valid_i;
   logic         blk_last_i;
   logic         blk_ready_o;
   logic [31:0]  ha_o, hb_o, hc_o, hd_o;
   logic [127:0] a_o;
   logic [127:0] mul_i;
   logic [127:0] ghash_o;
   logic         ghash_valid_o;
   logic         busy_o;

   int           n_pass = 0;
   int           n_total = 0;
   int           cyc = 0;
   logic [127:0] exp_q[$];
   logic [127:0] m_h;
   logic [127:0] m_acc;
   logic [127:0] mul_pipe [0:3];

   ghash_sequencer #(.DATA__WIDTH(128), .SPLIT_WIDTH(32), .MUL_LATENCY(4)) dut (
      .clk(clk), .rst(rst), .h_i(h_i), .h_load_i(h_load_i), .blk_i(blk_i),
      .blk_valid_i(blk_valid_i), .blk_last_i(blk_last_i), .blk_ready_o(blk_ready_o),
      .ha_o(ha_o), .hb_o(hb_o), .hc_o(hc_o), .hd_o(hd_o), .a_o(a_o), .mul_i(mul_i),
      .ghash_o(ghash_o), .ghash_valid_o(ghash_valid_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // GCM bit-reflected multiplication in GF(2^128).
   function automatic logic [127:0] gf_mult(input logic [127:0] x, input logic [127:0] y);
      logic [127:0] z = '0;
      logic [127:0] v = y;
      for (int i = 0; i < 128; i++) begin
         if (x[127-i]) z = z ^ v;
         v = v[0] ? ((v >> 1) ^ R_POLY) : (v >> 1);
      end
      return z;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial for (int i = 0; i < 4; i++) mul_pipe[i] = '0;
   always @(posedge clk) begin
      mul_pipe[0] <= gf_mult(a_o, {ha_o, hb_o, hc_o, hd_o});
      for (int i = 1; i < 4; i++) mul_pipe[i] <= mul_pipe[i-1];
   end
   assign mul_i = mul_pipe[3];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Message-level model: X = (X ^ block) * H per accepted block, hash on the last one.
   always @(negedge clk) begin
      if (rst) begin
         m_h   = '0;
         m_acc = '0;
         exp_q.delete();
      end else if (h_load_i && !busy_o) begin
         m_h   = h_i;
         m_acc = '0;
      end else if (blk_valid_i && blk_ready_o) begin
         m_acc = gf_mult(m_acc ^ blk_i, m_h);
         if (blk_last_i) begin
            exp_q.push_back(m_acc);
            m_acc = '0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && ghash_valid_o) begin
         if (exp_q.size() == 0) check("sb_unexpected_valid", 128'd1, 128'd0);
         else check("sb_ghash", ghash_o, exp_q.pop_front());
      end
   end

   task automatic wait_idle();
      bit ok = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (!busy_o) begin ok = 1; break; end
      end
      if (!ok) check("idle_timeout", 128'd0, 128'd1);
   endtask

   task automatic load_h(input logic [127:0] h);
      wait_idle();
      h_i = h; h_load_i = 1'b1;
      @(posedge clk); #1;
      h_load_i = 1'b0;
   endtask

   // Presents a block until accepted; returns the cycle in which it was accepted.
   task automatic send(input logic [127:0] d, input logic l, input bit keep, output int acc_cyc);
      bit ok = 0;
      blk_i = d; blk_last_i = l; blk_valid_i = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (blk_ready_o) begin ok = 1; break; end
      end
      acc_cyc = cyc;
      @(posedge clk); #1;
      if (!keep) blk_valid_i = 1'b0;
      if (!ok) check("accept_timeout", 128'd0, 128'd1);
   endtask

   task automatic wait_valid();
      bit ok = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (ghash_valid_o) begin ok = 1; break; end
      end
      if (!ok) check("valid_timeout", 128'd0, 128'd1);
   endtask

   initial begin
      int c1, c2, prev;
      logic [127:0] blk_a, blk_b;
      rst = 1'b1; h_i = '0; h_load_i = 1'b0; blk_i = '0; blk_valid_i = 1'b0; blk_last_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("rst_ready", 128'(blk_ready_o), 128'd1);
      check("rst_busy", 128'(busy_o), 128'd0);
      check("rst_a_o", a_o, 128'd0);
      check("rst_ghash", ghash_o, 128'd0);
      check("rst_valid", 128'(ghash_valid_o), 128'd0);

      // Identity H, single last block: exact cycle timeline.
      load_h(H_ID);
      check("h_split", {ha_o, hb_o, hc_o, hd_o}, H_ID);
      blk_a = 128'h0123456789ABCDEF0123456789ABCDEF;
      blk_i = blk_a; blk_last_i = 1'b1; blk_valid_i = 1'b1;
      @(posedge clk); #1;
      blk_valid_i = 1'b0;
      check("t1_a_o", a_o, blk_a);
      check("t1_ready_busy", 128'(blk_ready_o), 128'd0);
      repeat (4) @(posedge clk);
      #1 check("t5_valid", 128'(ghash_valid_o), 128'd0);
      @(posedge clk); #1;
      check("t6_valid", 128'(ghash_valid_o), 128'd1);
      check("t6_ghash", ghash_o, blk_a);
      @(posedge clk); #1;
      check("t7_valid", 128'(ghash_valid_o), 128'd0);
      check("t7_hold", ghash_o, blk_a);
      check("t7_a_o", a_o, 128'd0);

      // Two blocks under identity H.
      send({8'hFF, 120'h0}, 1'b0, 1'b0, c1);
      send({16{8'h0F}}, 1'b1, 1'b0, c2);
      check("two_blk_spacing", 128'((c2 - c1) >= 6), 128'd1);
      wait_valid();
      check("two_blk_ghash", ghash_o, {8'hF0, {15{8'h0F}}});

      // Reduction: x * x^127 = x^128.
      load_h(H_X);
      send(128'd1, 1'b1, 1'b0, c1);
      wait_valid();
      check("reduction", ghash_o, R_POLY);

      // H load and block offered together.
      wait_idle();
      blk_b = rnd128();
      h_i = H_ID; h_load_i = 1'b1; blk_i = blk_b; blk_last_i = 1'b1; blk_valid_i = 1'b1;
      @(negedge clk);
      check("hload_ready_low", 128'(blk_ready_o), 128'd0);
      @(posedge clk); #1;
      h_load_i = 1'b0;
      @(negedge clk);
      check("hload_ready_next", 128'(blk_ready_o), 128'd1);
      @(posedge clk); #1;
      blk_valid_i = 1'b0;
      check("hload_a_o", a_o, blk_b);
      wait_valid();
      check("hload_ghash", ghash_o, blk_b);

      // Reset while waiting on the multiplier.
      load_h(rnd128());
      send(rnd128(), 1'b1, 1'b0, c1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rstwait_busy", 128'(busy_o), 128'd0);
      check("rstwait_ghash", ghash_o, 128'd0);
      check("rstwait_split", {ha_o, hb_o, hc_o, hd_o}, 128'd0);
      repeat (10) @(posedge clk);
      #1;
      load_h(rnd128());
      send(rnd128(), 1'b0, 1'b0, c1);
      send(rnd128(), 1'b1, 1'b0, c1);
      wait_valid();

      // Back-to-back blocks with valid held high.
      load_h(rnd128());
      for (int i = 0; i < 8; i++) begin
         send(rnd128(), (i == 7), 1'b1, c2);
         if (i > 0) check("stream_interval", 128'(c2 - prev), 128'd6);
         prev = c2;
      end
      blk_valid_i = 1'b0;
      wait_valid();

      // Random messages with random gaps.
      for (int m = 0; m < 6; m++) begin
         int len;
         load_h(rnd128());
         len = $urandom_range(1, 4);
         for (int b = 0; b < len; b++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(rnd128(), (b == len - 1), 1'b0, c1);
         end
         wait_valid();
      end

      for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
      check("sb_drained", 128'(exp_q.size()), 128'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ghash_sequencer.md
GHASH_SEQUENCER -- requirements
Module: ghash_sequencer

Interface
REQ-001 SHALL have parameter DATA__WIDTH, default 128, meaning GHASH block width.
REQ-002 SHALL have parameter SPLIT_WIDTH, default 32, meaning H sub-word width driven to the multiplier.
REQ-003 SHALL have parameter MUL_LATENCY, default 4, meaning cycles from a_o presented to mul_i valid.
REQ-004 SHALL have port clk  input  1  meaning sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  meaning synchronous active-high reset.
REQ-006 SHALL have port h_i  input  DATA__WIDTH  meaning hash subkey H.
REQ-007 SHALL have port h_load_i  input  1  meaning load H and clear accumulator.
REQ-008 SHALL have port blk_i  input  DATA__WIDTH  meaning next AAD/ciphertext/length block.
REQ-009 SHALL have port blk_valid_i  input  1  meaning blk_i valid.
REQ-010 SHALL have port blk_last_i  input  1  meaning blk_i is the final (length) block.
REQ-011 SHALL have port blk_ready_o  output  1  meaning block accepted when high with blk_valid_i.
REQ-012 SHALL have ports ha_o, hb_o, hc_o, hd_o  output  SPLIT_WIDTH each  meaning H[127:96], H[95:64], H[63:32], H[31:0] to multiplier.
REQ-013 SHALL have port a_o  output  DATA__WIDTH  meaning multiplier operand (X xor block).
REQ-014 SHALL have port mul_i  input  DATA__WIDTH  meaning multiplier product.
REQ-015 SHALL have port ghash_o  output  DATA__WIDTH  meaning final GHASH value.
REQ-016 SHALL have port ghash_valid_o  output  1  meaning one-cycle pulse, ghash_o valid.
REQ-017 SHALL have port busy_o  output  1  meaning state not IDLE.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-019 SHALL drive blk_ready_o = 1 only in IDLE with h_load_i = 0.
REQ-020 SHALL, in IDLE with h_load_i = 1, load h_q <= h_i and z_q <= 0, accepting no block that cycle.
REQ-021 SHALL ignore h_load_i outside IDLE.
REQ-022 SHALL, on accept (blk_valid_i & blk_ready_o), register a_q <= blk_i xor z_q and last_q <= blk_last_i, then enter ISSUE.
REQ-023 SHALL drive a_o = a_q during ISSUE and a_o = 0 in every other state.
REQ-024 SHALL go ISSUE -> WAIT with counter loaded to MUL_LATENCY-1.
REQ-025 SHALL, in WAIT, decrement the counter each cycle; when counter = 0, capture z_q <= mul_i (the cycle MUL_LATENCY after ISSUE).
REQ-026 SHALL leave WAIT after capture: to DONE if last_q, else to IDLE.
REQ-027 SHALL, in DONE, assert ghash_valid_o = 1 for exactly one cycle with ghash_o = z_q, clear z_q <= 0, and return to IDLE.
REQ-028 SHALL hold ghash_o at its last value until the next DONE.
REQ-029 SHALL drive ha_o..hd_o continuously from h_q.
REQ-030 SHALL sustain one block per MUL_LATENCY+2 cycles (6 at default).
REQ-031 SHALL ignore blk_i/blk_last_i while blk_ready_o = 0.
REQ-032 SHALL treat a single last block as a complete message (ghash = blk * H).

Reset
REQ-033 SHALL, on rst, set state IDLE and h_q, z_q, a_q, ghash_o, counter, last_q to 0.
REQ-034 SHALL, during and after rst, drive ghash_valid_o = 0, busy_o = 0, a_o = 0, and blk_ready_o = 1 (the cycle after rst deasserts).
REQ-035 SHALL abandon any in-flight block on rst mid-operation and emit no ghash_valid_o for it.

Verification
REQ-036 SHALL cover: load H = 0x8000...0 (identity); send single last block 0x0123...CDEF accepted in cycle 0 -> a_o = block in cycle 1, ghash_valid_o in cycle 6, ghash_o = 0x0123...CDEF.
REQ-037 SHALL cover: H identity, blocks A1 = 0xFF00...0, A2 (last) = 0x0F0F...0F -> ghash_o = A1 xor A2; second accept no earlier than cycle 6.
REQ-038 SHALL cover: H = 0x4000...0 (x), last block 0x0000...0001 (x^127) -> ghash_o = 0xE100...0 (reduction check).
REQ-039 SHALL cover: h_load_i and blk_valid_i both high in IDLE -> H loaded, blk_ready_o = 0, block accepted next cycle.
REQ-040 SHALL cover: rst asserted in WAIT -> next cycle state IDLE, z_q = 0, no ghash_valid_o; new message afterwards gives correct result.
REQ-041 SHALL cover: blk_valid_i held high continuously with multiplier model of latency 4 -> blk_ready_o pulses every 6 cycles, result matches golden GHASH model.
